uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  UART serial transmitter. Accepts one parallel byte per handshake and emits a
//  frame on tx_out: start bit (0), DATA_WIDTH data bits LSB first, optional
//  parity bit, and one stop bit (1). This is the transmit-side counterpart of
//  the RX chain (start/parity/stop checkers), and it uses the same prescale
//  convention: one bit period = prescale CLK cycles.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame
//  PRE_W       6  width of prescale input and of the internal bit-period counter
// PORTS
//  CLK         in   1           system clock; all logic on rising edge
//  RST         in   1           synchronous reset, active-high
//  prescale    in   PRE_W       CLK cycles per bit (8/16/32 nominal)
//  data_in     in   DATA_WIDTH  byte to send
//  data_valid  in   1           request; accepted only while busy==0
//  par_en      in   1           1 = insert parity bit
//  par_typ     in   1           0 = even parity, 1 = odd parity
//  tx_out      out  1           serial line; idles high
//  busy        out  1           high from the cycle after acceptance to end of stop bit
// BEHAVIOUR
//  Reset: tx_out=1, busy=0, FSM=IDLE, counters=0. The same values apply the cycle
//   after RST is asserted mid-frame. The partial frame is abandoned and no
//   request is remembered.
//  FSM states: IDLE -> START -> DATA -> (PARITY if par_en latched) -> STOP -> IDLE.
//  IDLE: tx_out=1, busy=0. If data_valid=1, the block latches data_in, par_en,
//   par_typ and prescale in that cycle. The next state is START.
//  Prescale latch: a latched prescale below 2 is replaced by 2. Inputs that
//   change mid-frame have no effect.
//  Parity: computed from the latched data. Even parity = XOR of the data bits;
//   odd parity = its inverse.
//  Bit timing: bit_cnt runs from 0 to P-1, where P is the latched prescale.
//   Each non-IDLE state holds tx_out constant for exactly P cycles.
//  DATA: bit index runs 0..DATA_WIDTH-1. tx_out = data[idx]. The index advances
//   when bit_cnt = P-1.
//  STOP: tx_out=1. When bit_cnt = P-1, the next state is IDLE and busy falls on
//   the next cycle.
//  Latency: tx_out first goes low, and busy rises, one cycle after the accept
//   cycle. busy stays high for exactly (2+DATA_WIDTH+par_en)*P cycles.
//  data_valid while busy=1 is ignored; there is no queue. The upstream block
//   must hold data_valid until it sees busy.
//  Back-to-back frames: a new request is accepted at the earliest in the IDLE
//   cycle after STOP. This gives at least 1 idle-high CLK cycle between frames.
//  tx_out and busy are registered outputs (no combinational path from inputs).
//  All counters saturate or reset on state change; none wraps inside a state.
// TESTING
//  1 Reset: RST=1 for 3 cycles with data_valid=1 -> tx_out=1, busy=0, no frame
//    starts.
//  2 data_in=0xA5, prescale=8, par_en=1, par_typ=0 -> tx_out bit sequence
//    0,1,0,1,0,0,1,0,1,0,1, each bit 8 cycles. busy is high for 88 cycles.
//  3 Same byte, par_typ=1 -> parity bit=1. With par_en=0 -> no parity bit,
//    busy is high for 80 cycles.
//  4 data_valid toggled and data_in changed to 0xFF during the frame -> the
//    0xA5 frame is unchanged. The next frame starts only after busy=0 plus
//    1 idle cycle.
//  5 RST pulsed during DATA bit 3 -> the next cycle has tx_out=1, busy=0. A
//    fresh request for 0x3C then sends a complete, correct frame.
//  6 prescale=0 and prescale=1 -> each bit lasts 2 cycles. prescale=32 with
//    0x00 and odd parity -> parity bit=1, busy is high for 352 cycles.

Source files
------------

// File: rtl/uart_tx_frame_if.sv
// Byte-request and serial-line bundle for the UART frame transmitter.
// The master drives the byte and its framing options, and the slave returns the line and busy.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRE_W      = 6
);
    logic [PRE_W-1:0]      prescale;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic                  tx_out;
    logic                  busy;

    modport master (
        output prescale, data_in, data_valid, par_en, par_typ,
        input  tx_out, busy
    );

    modport slave (
        input  prescale, data_in, data_valid, par_en, par_typ,
        output tx_out, busy
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, LSB-first data, optional parity, stop.
// Each bit lasts the prescale value latched at acceptance, with a floor of 2 clocks.
//
// state  | meaning
// IDLE   | line high, waiting for data_valid
// START  | start bit (0)
// DATA   | data bit idx_q
// PARITY | parity bit (only if par_en latched)
// STOP   | stop bit (1)
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRE_W      = 6
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_frame_if.slave bus
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [PRE_W-1:0] PRE_MIN  = PRE_W'(2);
    localparam logic [PRE_W-1:0] CNT_ONE  = PRE_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    logic [2:0]            state_q,   state_d;
    logic [PRE_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic [PRE_W-1:0]      pre_q,     pre_d;
    logic                  par_en_q,  par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  tx_q,      tx_d;
    logic                  busy_q,    busy_d;

    logic                  last_cycle;
    logic                  par_bit;
    logic [IDX_W-1:0]      idx_next;

    assign last_cycle = (bit_cnt_q == (pre_q - CNT_ONE));
    assign par_bit    = (^data_q) ^ par_typ_q;
    assign idx_next   = idx_q + IDX_ONE;

    // tx_d carries the level of the state being entered, so tx_out changes on
    // the same edge as the state and stays flat for the whole bit period.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        pre_d     = pre_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        tx_d      = tx_q;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                idx_d     = '0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
                if (bus.data_valid) begin
                    data_d    = bus.data_in;
                    par_en_d  = bus.par_en;
                    par_typ_d = bus.par_typ;
                    pre_d     = (bus.prescale < PRE_MIN) ? PRE_MIN : bus.prescale;
                    state_d   = START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (last_cycle) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                    tx_d      = data_q[0];
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (last_cycle) begin
                    bit_cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_next;
                        tx_d  = data_q[idx_next];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end
            PARITY: begin
                if (last_cycle) begin
                    bit_cnt_d = '0;
                    state_d   = STOP;
                    tx_d      = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end
            STOP: begin
                if (last_cycle) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                    tx_d      = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                idx_d     = '0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            pre_q     <= PRE_MIN;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            pre_q     <= pre_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.tx_out = tx_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: expected bit sequences are hand-written in
// transmission order, and tx_out is checked on every clock of every bit.
module tb_uart_tx_frame;
    logic clk;
    logic rst;
    int   total;
    int   passed;

    uart_tx_frame_if #(.DATA_WIDTH(8), .PRE_W(6)) bus ();

    uart_tx_frame #(.DATA_WIDTH(8), .PRE_W(6)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // seq holds the frame in transmission order starting at index 0.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [5:0] pre,
                             input logic pen, input logic ptyp, input logic [0:11] seq,
                             input int nbits, input int pbit, input int exp_busy,
                             input logic disturb);
        int busy_cnt;
        bus.data_in    = d;
        bus.prescale   = pre;
        bus.par_en     = pen;
        bus.par_typ    = ptyp;
        bus.data_valid = 1'b1;
        step();
        busy_cnt = 0;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < pbit; c++) begin
                check($sformatf("%s_tx_b%0d_c%0d", tag, b, c), 32'(bus.tx_out), 32'(seq[b]));
                if (bus.busy === 1'b1) busy_cnt++;
                if (disturb) begin
                    bus.data_valid = c[0];
                    bus.data_in    = 8'hFF;
                    bus.prescale   = 6'd3;
                    bus.par_en     = ~pen;
                    bus.par_typ    = ~ptyp;
                end else begin
                    bus.data_valid = 1'b0;
                end
                step();
            end
        end
        check({tag, "_busy_len"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_end_tx"},   32'(bus.tx_out), 32'd1);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst            = 1'b1;
        bus.data_in    = 8'h5A;
        bus.prescale   = 6'd8;
        bus.par_en     = 1'b0;
        bus.par_typ    = 1'b0;
        bus.data_valid = 1'b1;

        // Reset held with a pending request.
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_tx_%0d", i),   32'(bus.tx_out), 32'd1);
            check($sformatf("rst_busy_%0d", i), 32'(bus.busy),   32'd0);
        end
        rst            = 1'b0;
        bus.data_valid = 1'b0;
        step();
        check("post_rst_tx",   32'(bus.tx_out), 32'd1);
        check("post_rst_busy", 32'(bus.busy),   32'd0);
        step();
        check("post_rst_busy2", 32'(bus.busy), 32'd0);

        run_frame("a5_even", 8'hA5, 6'd8, 1'b1, 1'b0, 12'b0101_0010_1010, 11, 8, 88, 1'b0);
        run_frame("a5_odd",  8'hA5, 6'd8, 1'b1, 1'b1, 12'b0101_0010_1110, 11, 8, 88, 1'b0);
        run_frame("a5_nopar", 8'hA5, 6'd8, 1'b0, 1'b0, 12'b0101_0010_1100, 10, 8, 80, 1'b0);

        // Inputs wiggle during the frame; data_valid is left high at the end,
        // so the 0xFF frame must start right after the single idle cycle.
        run_frame("a5_disturb", 8'hA5, 6'd8, 1'b1, 1'b0, 12'b0101_0010_1010, 11, 8, 88, 1'b1);
        run_frame("ff_next",    8'hFF, 6'd8, 1'b1, 1'b0, 12'b0111_1111_1010, 11, 8, 88, 1'b0);

        // Abort in data bit 3: 1 accept step + 8 start + 24 data + 3 into bit 3.
        bus.data_in    = 8'hA5;
        bus.prescale   = 6'd8;
        bus.par_en     = 1'b0;
        bus.par_typ    = 1'b0;
        bus.data_valid = 1'b1;
        step();
        bus.data_valid = 1'b0;
        repeat (35) step();
        check("abort_pre_tx",   32'(bus.tx_out), 32'd0);
        check("abort_pre_busy", 32'(bus.busy),   32'd1);
        rst = 1'b1;
        step();
        check("abort_tx",   32'(bus.tx_out), 32'd1);
        check("abort_busy", 32'(bus.busy),   32'd0);
        rst = 1'b0;
        step();
        check("abort_idle_tx",   32'(bus.tx_out), 32'd1);
        check("abort_idle_busy", 32'(bus.busy),   32'd0);
        run_frame("3c_odd", 8'h3C, 6'd8, 1'b1, 1'b1, 12'b0001_1110_0110, 11, 8, 88, 1'b0);

        // Prescale floor and the widest nominal prescale.
        run_frame("5a_pre0", 8'h5A, 6'd0,  1'b0, 1'b0, 12'b0010_1101_0100, 10, 2,  20,  1'b0);
        run_frame("c3_pre1", 8'hC3, 6'd1,  1'b1, 1'b0, 12'b0110_0001_1010, 11, 2,  22,  1'b0);
        run_frame("00_pre32", 8'h00, 6'd32, 1'b1, 1'b1, 12'b0000_0000_0110, 11, 32, 352, 1'b0);

        step();
        check("final_idle_busy", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
